// File: rtl/ram_window_reader.sv
// ram_window_reader
// Streams a run of overlapping 8-word windows out of a 1-write/8-read RAM.
// Lane k of window j comes from address (base + j*STEP + k), wrapping at the
// top of memory. Windows are handed off downstream through a valid/ready
// output register. A job is started from IDLE, runs until its last window
// is captured, then drains that last window and pulses done_o.

module ram_window_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int STEP       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [ADDR_WIDTH:0]     count_i,
    input  logic                    abort_i,
    output logic                    read_en_o,
    output logic [ADDR_WIDTH-1:0]   read_addr0_o,
    output logic [ADDR_WIDTH-1:0]   read_addr1_o,
    output logic [ADDR_WIDTH-1:0]   read_addr2_o,
    output logic [ADDR_WIDTH-1:0]   read_addr3_o,
    output logic [ADDR_WIDTH-1:0]   read_addr4_o,
    output logic [ADDR_WIDTH-1:0]   read_addr5_o,
    output logic [ADDR_WIDTH-1:0]   read_addr6_o,
    output logic [ADDR_WIDTH-1:0]   read_addr7_o,
    input  logic [DATA_WIDTH-1:0]   data0_i,
    input  logic [DATA_WIDTH-1:0]   data1_i,
    input  logic [DATA_WIDTH-1:0]   data2_i,
    input  logic [DATA_WIDTH-1:0]   data3_i,
    input  logic [DATA_WIDTH-1:0]   data4_i,
    input  logic [DATA_WIDTH-1:0]   data5_i,
    input  logic [DATA_WIDTH-1:0]   data6_i,
    input  logic [DATA_WIDTH-1:0]   data7_i,
    output logic                    win_valid_o,
    input  logic                    win_ready_i,
    output logic [8*DATA_WIDTH-1:0] win_data_o,
    output logic                    win_last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP_ADDR = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ZERO  = (ADDR_WIDTH+1)'(0);

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   ptr_r;
    logic [ADDR_WIDTH:0]     rem_r;
    logic                    capture_s;

    // Lane address: natural modulo wrap of the ADDR_WIDTH-bit sum.
    function automatic logic [ADDR_WIDTH-1:0] lane_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input int                    lane
    );
        lane_addr = base + ADDR_WIDTH'(lane);
    endfunction

    // A window is taken when running and the output register is free or
    // being emptied this cycle; abort cancels the capture outright.
    assign capture_s = (state_r == ST_RUN) && (!win_valid_o || win_ready_i) && !abort_i;

    assign read_en_o    = capture_s;
    assign busy_o       = (state_r != ST_IDLE);
    assign read_addr0_o = lane_addr(ptr_r, 0);
    assign read_addr1_o = lane_addr(ptr_r, 1);
    assign read_addr2_o = lane_addr(ptr_r, 2);
    assign read_addr3_o = lane_addr(ptr_r, 3);
    assign read_addr4_o = lane_addr(ptr_r, 4);
    assign read_addr5_o = lane_addr(ptr_r, 5);
    assign read_addr6_o = lane_addr(ptr_r, 6);
    assign read_addr7_o = lane_addr(ptr_r, 7);

    // Job FSM together with the window output register and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            rem_r       <= '0;
            win_valid_o <= 1'b0;
            win_last_o  <= 1'b0;
            win_data_o  <= '0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state_r     <= ST_IDLE;
                win_valid_o <= 1'b0;
                win_last_o  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_i) begin
                            ptr_r <= base_addr_i;
                            rem_r <= count_i;
                            if (count_i == REM_ZERO) begin
                                // Empty job: report completion without a window.
                                state_r <= ST_IDLE;
                                done_o  <= 1'b1;
                            end else begin
                                state_r <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (capture_s) begin
                            win_data_o  <= {data7_i, data6_i, data5_i, data4_i,
                                            data3_i, data2_i, data1_i, data0_i};
                            win_valid_o <= 1'b1;
                            win_last_o  <= (rem_r == REM_ONE);
                            ptr_r       <= ptr_r + STEP_ADDR;
                            rem_r       <= rem_r - REM_ONE;
                            if (rem_r == REM_ONE) begin
                                state_r <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (win_valid_o && win_ready_i) begin
                            win_valid_o <= 1'b0;
                            win_last_o  <= 1'b0;
                            state_r     <= ST_IDLE;
                            done_o      <= 1'b1;
                        end
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        win_valid_o <= 1'b0;
                        win_last_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_window_reader.sv
// Bench for ram_window_reader: RAM model with mem[i]=i, scoreboard of
// expected windows checked on every accepted transfer, a table of jobs,
// and hand-written sequences for timing, backpressure, abort and reset.

module tb_ram_window_reader;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int WW = 8 * DW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          abort;
    logic          read_en;
    logic [AW-1:0] ra0, ra1, ra2, ra3, ra4, ra5, ra6, ra7;
    logic [DW-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic          win_valid;
    logic          win_ready;
    logic [WW-1:0] win_data;
    logic          win_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [1024];

    typedef struct packed {
        logic [WW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        int base;
        int cnt;
        int stall;
    } job_t;

    exp_t sb_q[$];
    int   total;
    int   bad;
    int   done_cnt;
    int   acc_cnt;

    ram_window_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base_addr),
        .count_i(count), .abort_i(abort), .read_en_o(read_en),
        .read_addr0_o(ra0), .read_addr1_o(ra1), .read_addr2_o(ra2), .read_addr3_o(ra3),
        .read_addr4_o(ra4), .read_addr5_o(ra5), .read_addr6_o(ra6), .read_addr7_o(ra7),
        .data0_i(d0), .data1_i(d1), .data2_i(d2), .data3_i(d3),
        .data4_i(d4), .data5_i(d5), .data6_i(d6), .data7_i(d7),
        .win_valid_o(win_valid), .win_ready_i(win_ready), .win_data_o(win_data),
        .win_last_o(win_last), .busy_o(busy), .done_o(done)
    );

    assign d0 = mem[ra0];
    assign d1 = mem[ra1];
    assign d2 = mem[ra2];
    assign d3 = mem[ra3];
    assign d4 = mem[ra4];
    assign d5 = mem[ra5];
    assign d6 = mem[ra6];
    assign d7 = mem[ra7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WW-1:0] exp_win(input logic [AW-1:0] a);
        logic [WW-1:0] w;
        logic [AW-1:0] ak;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            ak = a + AW'(k);
            w[k*DW +: DW] = {22'd0, ak};
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_job(input int b, input int c);
        logic [AW-1:0] a;
        exp_t e;
        for (int j = 0; j < c; j++) begin
            a = AW'(b) + AW'(j);
            e.data = exp_win(a);
            e.last = (j == c - 1);
            sb_q.push_back(e);
        end
    endtask

    // Drives a start pulse; returns 1 time unit after the start edge.
    task automatic start_job(input int b, input int c);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(b);
        count     = (AW+1)'(c);
        push_job(b, c);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input int stall, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            #1;
            if (stall > 0) win_ready = (($urandom % stall) != 0);
            else           win_ready = 1'b1;
            n++;
        end
        win_ready = 1'b1;
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL done_timeout got=no_done exp=done within %0d cycles", budget);
        end
    endtask

    // Scoreboard: every accepted window is popped and compared.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (win_valid && win_ready) begin
            acc_cnt++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra got=%h exp=no_window", win_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (win_data !== e.data || win_last !== e.last) begin
                    bad++;
                    $display("FAIL sb_window got=%h/%b exp=%h/%b", win_data, win_last, e.data, e.last);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        job_t tbl[7];
        tbl[0] = '{0, 3, 0};
        tbl[1] = '{1020, 2, 0};
        tbl[2] = '{100, 8, 0};
        tbl[3] = '{5, 1, 0};
        tbl[4] = '{1016, 12, 3};
        tbl[5] = '{0, 0, 0};
        tbl[6] = '{512, 1024, 0};

        total = 0; bad = 0; done_cnt = 0; acc_cnt = 0;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; win_ready = 1'b1;
        base_addr = '0; count = '0;
        #23;
        check("rst_valid", win_valid, 0);
        check("rst_last", win_last, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_read_en", read_en, 0);
        check("rst_data", win_data, 0);
        check("rst_addr0", ra0, 0);
        check("rst_addr7", ra7, 7);
        rst_n = 1'b1;

        // Latency and back-to-back timing with ready held high.
        done_cnt = 0; acc_cnt = 0;
        start_job(0, 3);
        @(negedge clk);
        check("lat_valid0", win_valid, 0);
        check("lat_read_en", read_en, 1);
        check("lat_busy", busy, 1);
        @(negedge clk);
        check("win0", win_data, exp_win(10'd0));
        check("win0_last", win_last, 0);
        @(negedge clk);
        check("win1", win_data, exp_win(10'd1));
        @(negedge clk);
        check("win2", win_data, exp_win(10'd2));
        check("win2_last", win_last, 1);
        check("win2_done", done, 0);
        @(negedge clk);
        check("drain_valid", win_valid, 0);
        check("drain_done", done, 1);
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("idle_busy", busy, 0);

        // Backpressure: output must hold while ready is low.
        done_cnt = 0; acc_cnt = 0;
        win_ready = 1'b0;
        start_job(0, 3);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("bp_data", win_data, exp_win(10'd0));
            check("bp_valid", win_valid, 1);
            check("bp_read_en", read_en, 0);
            check("bp_addr0", ra0, 1);
            @(negedge clk);
        end
        win_ready = 1'b1;
        run_until_done(0, 50);
        check("bp_acc", acc_cnt, 3);
        check("bp_sb_empty", sb_q.size(), 0);

        // Empty job.
        done_cnt = 0; acc_cnt = 0;
        start_job(0, 0);
        @(negedge clk);
        check("c0_done", done, 1);
        check("c0_busy", busy, 0);
        check("c0_valid", win_valid, 0);
        repeat (3) @(negedge clk);
        check("c0_done_cnt", done_cnt, 1);
        check("c0_acc", acc_cnt, 0);

        // Start while busy is ignored.
        done_cnt = 0; acc_cnt = 0;
        start_job(0, 4);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 10'd500; count = 11'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_until_done(0, 50);
        @(negedge clk);
        check("busy_start_acc", acc_cnt, 4);
        check("busy_start_sb", sb_q.size(), 0);

        // Abort during window 2, then a fresh job.
        for (int pass = 0; pass < 2; pass++) begin
            done_cnt = 0; acc_cnt = 0;
            start_job(0, 5);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            win_ready = 1'b0;
            if (pass == 0) begin
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
            end else begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_async_valid", win_valid, 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            check("cancel_valid", win_valid, 0);
            check("cancel_busy", busy, 0);
            check("cancel_last", win_last, 0);
            sb_q.delete();
            win_ready = 1'b1;
            repeat (4) @(negedge clk);
            check("cancel_no_done", done_cnt, 0);
            check("cancel_acc", acc_cnt, 1);
            check("cancel_idle_valid", win_valid, 0);
            done_cnt = 0; acc_cnt = 0;
            start_job(8, 1);
            run_until_done(0, 20);
            @(negedge clk);
            check("post_cancel_acc", acc_cnt, 1);
            check("post_cancel_sb", sb_q.size(), 0);
        end

        // Table of jobs checked through the scoreboard.
        for (int t = 0; t < 7; t++) begin
            done_cnt = 0; acc_cnt = 0;
            start_job(tbl[t].base, tbl[t].cnt);
            run_until_done(tbl[t].stall, 4000);
            @(negedge clk);
            check("tbl_acc", acc_cnt, tbl[t].cnt);
            check("tbl_sb_empty", sb_q.size(), 0);
            check("tbl_done_cnt", done_cnt, 1);
            check("tbl_busy", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_window_reader.md
RAM_WINDOW_READER -- requirements
Module: ram_window_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, the RAM address width; memory depth is 2**ADDR_WIDTH.
REQ-003 SHALL have parameter STEP, default 1, the address advance between consecutive windows (1 to 2**ADDR_WIDTH-1).
REQ-004 SHALL have the following ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  job request, sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  address of lane 0 of window 0.
- count_i  in  ADDR_WIDTH+1  number of windows in the job (0 to 2**ADDR_WIDTH).
- abort_i  in  1  synchronous job cancel.
- read_en_o  out  1  high in every cycle a window is captured.
- read_addr0_o..read_addr7_o  out  ADDR_WIDTH each  lane read addresses to the 1-write/8-read RAM.
- data0_i..data7_i  in  DATA_WIDTH each  combinational RAM read data for lanes 0..7.
- win_valid_o  out  1  output window valid.
- win_ready_i  in  1  downstream accepts the window.
- win_data_o  out  8*DATA_WIDTH  lane k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- win_last_o  out  1  marks the final window of a job; qualified by win_valid_o.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when a job completes.

Function
REQ-005 SHALL implement the FSM IDLE -> RUN -> DRAIN -> IDLE; busy_o SHALL equal (state != IDLE).
REQ-006 In IDLE, a high start_i at an edge SHALL load ptr=base_addr_i and rem=count_i, and move to RUN; if count_i=0, the FSM SHALL go to IDLE instead and pulse done_o in the next cycle.
REQ-007 start_i SHALL be ignored outside IDLE.
REQ-008 read_addrk_o SHALL be (ptr+k) mod 2**ADDR_WIDTH for k=0..7 in all states; there is no saturation at the top of memory.
REQ-009 In RUN, capture SHALL occur when (!win_valid_o || win_ready_i): win_data_o <= {data7_i..data0_i}, win_valid_o <= 1, ptr <= (ptr+STEP) mod 2**ADDR_WIDTH, rem <= rem-1; read_en_o SHALL be high in exactly the capture cycles.
REQ-010 win_last_o SHALL be set on the capture where rem=1; that capture SHALL move the FSM to DRAIN.
REQ-011 While win_valid_o=1 and win_ready_i=0, win_data_o and win_last_o SHALL hold stable and ptr/rem SHALL not change.
REQ-012 In DRAIN, when win_valid_o && win_ready_i, the block SHALL clear win_valid_o, go to IDLE and pulse done_o for one cycle.
REQ-013 With win_ready_i held high, throughput SHALL be one window per cycle; the first win_valid_o SHALL rise one cycle after the start edge (latency 1).
REQ-014 win_valid_o SHALL be cleared by a window acceptance with no new capture (win_valid_o && win_ready_i).
REQ-015 A high abort_i SHALL take priority over all other events in any state: go to IDLE, clear win_valid_o and win_last_o, no done_o pulse.
REQ-016 Same-cycle RAM writes to a read address SHALL be handled by the RAM; this block SHALL capture whatever data0_i..data7_i present at the capture edge.

Reset
REQ-017 On rst_n low, asynchronously: state=IDLE; ptr=0; rem=0; win_valid_o=0; win_last_o=0; done_o=0; win_data_o=0; read_en_o=0; busy_o=0.
REQ-018 Reset asserted mid-job SHALL discard the job; after release the block SHALL be in IDLE and output no window and no done_o pulse.

Verification
REQ-019 mem[i]=i, base=0, count=3, ready=1 -> windows {0..7}, {1..8}, {2..9} on 3 consecutive cycles; win_last_o on the 3rd; done_o one cycle later.
REQ-020 Wrap-around, ADDR_WIDTH=10, base=1020, count=2 -> lanes 1020,1021,1022,1023,0,1,2,3, then 1021,1022,1023,0..4.
REQ-021 Backpressure: ready=0 for 3 cycles after the first valid -> win_data_o stable {0..7}, read_en_o=0; ready=1 -> remaining windows follow in order.
REQ-022 count=0 -> no win_valid_o; done_o pulses 1 cycle after start; a start while busy, sent mid-job, is ignored (window sequence unchanged).
REQ-023 abort_i, or rst_n low, during window 2 of count=5 -> win_valid_o=0 next cycle, busy_o=0, no done_o; a following job with base=8, count=1 yields window {8..15}.
